// File: rtl/seg_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_driver_pkg
// Shared definitions for the multiplexed seven-segment display driver:
//   page_e      - displayed page encoding (time / date / year)
//   SEG_BLANK   - active-low segment pattern with every segment off
//   NUM_DIGITS  - number of scanned digit positions
//   next_page() - page rotation order used on a button press
// ---------------------------------------------------------------------------
package seg_scan_driver_pkg;

  typedef enum logic [1:0] {
    PAGE_TIME = 2'd0,
    PAGE_DATE = 2'd1,
    PAGE_YEAR = 2'd2
  } page_e;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         NUM_DIGITS = 6;

  function automatic page_e next_page(input page_e p);
    case (p)
      PAGE_TIME: return PAGE_DATE;
      PAGE_DATE: return PAGE_YEAR;
      default:   return PAGE_TIME;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw active-low push button, debounces it and emits a
// single-cycle pulse when the debounced level falls (button pressed).
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   btn_n       - raw button, active-low, asynchronous to clk
//   press_pulse - one clk cycle high, the cycle after the debounced level
//                 falls
// The debounced level flips only after DEBOUNCE_CYC consecutive cycles in
// which the synchronised input disagrees with it; any agreeing cycle
// restarts the count.
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync0;
  logic             sync1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0       <= 1'b1;
      sync1       <= 1'b1;
      level       <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync0       <= btn_n;
      sync1       <= sync0;
      press_pulse <= 1'b0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level       <= sync1;
        cnt         <= '0;
        press_pulse <= ~sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a 6-digit common-anode seven-segment display.
// A page button cycles the display between time (hh mm ss), date
// (dd mm yy) and the full 4-digit year.
//   built_in_clk           - system clock
//   glob_rst_n             - asynchronous active-low reset
//   btn_page_n             - raw page button, active-low
//   s_*                    - active-low digit codes {g..a}
//   seg_out                - active-low segment drive
//   dig_sel_n              - active-low one-hot digit enable, bit 0 rightmost
//   page                   - current page (0 time, 1 date, 2 year)
// Digit codes are sampled only on a slot wrap, so a digit never tears.
// All outputs are functions of registers only.
// ---------------------------------------------------------------------------
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       built_in_clk,
  input  logic       glob_rst_n,
  input  logic       btn_page_n,
  input  logic [6:0] s_sec0,
  input  logic [6:0] s_sec1,
  input  logic [6:0] s_min0,
  input  logic [6:0] s_min1,
  input  logic [6:0] s_hour0,
  input  logic [6:0] s_hour1,
  input  logic [6:0] s_day0,
  input  logic [6:0] s_day1,
  input  logic [6:0] s_mon0,
  input  logic [6:0] s_mon1,
  input  logic [6:0] s_year0,
  input  logic [6:0] s_year1,
  input  logic [6:0] s_year2,
  input  logic [6:0] s_year3,
  output logic [6:0] seg_out,
  output logic [5:0] dig_sel_n,
  output logic [1:0] page
);

  localparam int               SLOT_W    = $clog2(SCAN_DIV + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYC);
  localparam logic [2:0]        LAST_DIG  = 3'(NUM_DIGITS - 1);

  // NOTE: reset asserts asynchronously but releases through two flops, so
  // every register leaves reset on the same clock edge.
  logic [1:0] rst_ff;
  logic       rst_n;

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) rst_ff <= 2'b00;
    else             rst_ff <= {rst_ff[0], 1'b1};
  end

  assign rst_n = rst_ff[1];

  logic press_pulse;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk        (built_in_clk),
    .rst_n      (rst_n),
    .btn_n      (btn_page_n),
    .press_pulse(press_pulse)
  );

  logic [SLOT_W-1:0] slot_cnt;
  logic [2:0]        dig_idx;
  page_e             page_q;
  logic              pend;
  logic [6:0]        code_q;

  logic       slot_wrap;
  logic       frame_wrap;
  logic [2:0] dig_idx_nxt;
  page_e      page_nxt;
  logic       pend_nxt;
  logic [6:0] cap_code;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (dig_idx == LAST_DIG);

  // A pending advance is consumed at the frame boundary; a press arriving
  // on that same edge stays pending for the following boundary.
  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    dig_idx_nxt = (dig_idx == LAST_DIG) ? 3'd0 : dig_idx + 3'd1;
    page_nxt    = page_q;
    pend_nxt    = pend | press_pulse;
    if (frame_wrap && pend) begin
      page_nxt = next_page(page_q);
      pend_nxt = press_pulse;
    end
  end

  // Code for the digit about to be selected, on the page that will be in
  // force for it (the new page already applies to digit 0 of a frame).
  always_comb begin
    cap_code = SEG_BLANK;
    case (page_nxt)
      PAGE_TIME: begin
        case (dig_idx_nxt)
          3'd0:    cap_code = s_sec0;
          3'd1:    cap_code = s_sec1;
          3'd2:    cap_code = s_min0;
          3'd3:    cap_code = s_min1;
          3'd4:    cap_code = s_hour0;
          3'd5:    cap_code = s_hour1;
          default: cap_code = SEG_BLANK;
        endcase
      end
      PAGE_DATE: begin
        case (dig_idx_nxt)
          3'd0:    cap_code = s_year0;
          3'd1:    cap_code = s_year1;
          3'd2:    cap_code = s_mon0;
          3'd3:    cap_code = s_mon1;
          3'd4:    cap_code = s_day0;
          3'd5:    cap_code = s_day1;
          default: cap_code = SEG_BLANK;
        endcase
      end
      PAGE_YEAR: begin
        case (dig_idx_nxt)
          3'd0:    cap_code = s_year0;
          3'd1:    cap_code = s_year1;
          3'd2:    cap_code = s_year2;
          3'd3:    cap_code = s_year3;
          default: cap_code = SEG_BLANK;
        endcase
      end
      default: cap_code = SEG_BLANK;
    endcase
  end

  always_ff @(posedge built_in_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= 3'd0;
      page_q   <= PAGE_TIME;
      pend     <= 1'b0;
      code_q   <= SEG_BLANK;
    end else begin
      pend   <= pend_nxt;
      page_q <= page_nxt;
      if (slot_wrap) begin
        slot_cnt <= '0;
        dig_idx  <= dig_idx_nxt;
        code_q   <= cap_code;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // Leading cycles of every slot are dark so the previous digit's segments
  // do not ghost onto the newly selected digit.
  assign seg_out   = (slot_cnt < BLANK_END) ? SEG_BLANK : code_q;
  assign dig_sel_n = ~(6'b000001 << dig_idx);
  assign page      = page_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench: a cycle-count based reference model predicts
// seg_out / dig_sel_n / page every cycle; directed sections add literal
// expectations, followed by a randomized digit / button / reset phase.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int SD = 8;       // SCAN_DIV
  localparam int BC = 2;       // BLANK_CYC
  localparam int DC = 4;       // DEBOUNCE_CYC
  localparam int FR = SD * 6;  // cycles per frame

  logic       clk        = 1'b0;
  logic       glob_rst_n = 1'b1;
  logic       btn        = 1'b1;
  logic [6:0] din [14];        // sec0 sec1 min0 min1 hour0 hour1 day0 day1 mon0 mon1 year0..3
  logic [6:0] seg_out;
  logic [5:0] dig_sel_n;
  logic [1:0] page;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV(SD), .BLANK_CYC(BC), .DEBOUNCE_CYC(DC)
  ) dut (
    .built_in_clk(clk),
    .glob_rst_n  (glob_rst_n),
    .btn_page_n  (btn),
    .s_sec0 (din[0]),  .s_sec1 (din[1]),
    .s_min0 (din[2]),  .s_min1 (din[3]),
    .s_hour0(din[4]),  .s_hour1(din[5]),
    .s_day0 (din[6]),  .s_day1 (din[7]),
    .s_mon0 (din[8]),  .s_mon1 (din[9]),
    .s_year0(din[10]), .s_year1(din[11]),
    .s_year2(din[12]), .s_year3(din[13]),
    .seg_out  (seg_out),
    .dig_sel_n(dig_sel_n),
    .page     (page)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // rel: edges since reset release (saturates at 2, the synchroniser depth).
  // t:   running cycles since the internal reset released.
  int         rel       = 0;
  int         t         = 0;
  bit         hist0     = 1'b1;
  bit         hist1     = 1'b1;
  bit         deb       = 1'b1;
  int         run       = 0;
  bit         press_due = 1'b0;
  bit         pend_m    = 1'b0;
  int         page_m    = 0;
  logic [6:0] code_m    = 7'h7F;
  int         date_map [6] = '{10, 11, 8, 9, 6, 7};

  function automatic logic [6:0] exp_digit(input int pg, input int idx);
    if (pg == 0) return din[idx];
    if (pg == 1) return din[date_map[idx]];
    if (idx < 4) return din[10 + idx];
    return 7'h7F;
  endfunction

  task automatic model_reset();
    rel = 0; t = 0; hist0 = 1'b1; hist1 = 1'b1; deb = 1'b1; run = 0;
    press_due = 1'b0; pend_m = 1'b0; page_m = 0; code_m = 7'h7F;
  endtask

  task automatic model_step();
    bit synced;
    bit press_now;
    int idx;
    synced    = hist1;
    hist1     = hist0;
    hist0     = btn;
    press_now = press_due;
    press_due = 1'b0;
    if (synced != deb) begin
      run++;
      if (run == DC) begin
        deb       = synced;
        run       = 0;
        press_due = !synced;
      end
    end else begin
      run = 0;
    end
    t++;
    if (t % SD == 0) begin
      idx = (t / SD) % 6;
      if (idx == 0 && pend_m) begin
        page_m = (page_m + 1) % 3;
        pend_m = press_now;
      end else begin
        pend_m = pend_m | press_now;
      end
      code_m = exp_digit(page_m, idx);
    end else begin
      pend_m = pend_m | press_now;
    end
  endtask

  always @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) model_reset();
    else if (rel >= 2) model_step();
    else rel++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [6:0] e_seg;
    logic [5:0] e_dig;
    e_seg = ((t % SD) < BC) ? 7'h7F : code_m;
    e_dig = ~(6'(1) << ((t / SD) % 6));
    check("model seg_out",   32'(seg_out),   32'(e_seg));
    check("model dig_sel_n", 32'(dig_sel_n), 32'(e_dig));
    check("model page",      32'(page),      32'(page_m));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_mod(input int m);
    int g;
    g = 0;
    tick();
    while ((t % FR) != m && g < 400) begin
      tick();
      g++;
    end
    if (g >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_mod timeout: got no frame offset %0d expected within 400 cycles", m);
    end
  endtask

  task automatic wait_frame();
    wait_mod(0);
  endtask

  task automatic press();
    btn = 1'b0;
    repeat (10) tick();
    btn = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    int hold;
    for (int i = 0; i < 14; i++) din[i] = 7'($urandom_range(0, 126));
    din[0]  = 7'h40;
    din[3]  = 7'h79;
    din[6]  = 7'h12;
    din[10] = 7'h30;

    // Reset
    #1 glob_rst_n = 1'b0;
    repeat (3) tick();
    check("reset seg_out",   32'(seg_out),   32'h7F);
    check("reset dig_sel_n", 32'(dig_sel_n), 32'h3E);
    check("reset page",      32'(page),      32'd0);
    glob_rst_n = 1'b1;
    // two synchroniser cycles, then one full slot of SD cycles
    repeat (9) tick();
    check("release dig_sel_n before wrap", 32'(dig_sel_n), 32'h3E);
    tick();
    check("release dig_sel_n after wrap",  32'(dig_sel_n), 32'h3D);

    // Scan and blanking
    wait_frame();
    for (int i = 0; i < SD; i++) begin
      check("scan slot0 seg", 32'(seg_out), (i < BC) ? 32'h7F : 32'h40);
      tick();
    end
    wait_mod(24);
    for (int i = 0; i < SD; i++) begin
      check("scan slot3 dig", 32'(dig_sel_n), 32'h37);
      check("scan slot3 seg", 32'(seg_out), (i < BC) ? 32'h7F : 32'h79);
      tick();
    end

    // Mid-slot change does not tear
    wait_frame();
    repeat (4) tick();
    din[0] = 7'h24;
    for (int i = 4; i < SD; i++) begin
      check("midslot hold seg", 32'(seg_out), 32'h40);
      tick();
    end
    wait_frame();
    repeat (2) tick();
    check("midslot next frame seg", 32'(seg_out), 32'h24);

    // Debounce glitch rejected
    wait_frame();
    btn = 1'b0;
    repeat (3) tick();
    btn = 1'b1;
    wait_frame();
    wait_frame();
    check("glitch page", 32'(page), 32'd0);

    // Clean press
    wait_frame();
    btn = 1'b0;
    repeat (10) tick();
    btn = 1'b1;
    wait_mod(FR - 1);
    check("press page before boundary", 32'(page), 32'd0);
    tick();
    check("press page at boundary", 32'(page), 32'd1);
    wait_mod(34);
    check("date slot4 dig", 32'(dig_sel_n), 32'h2F);
    check("date slot4 seg", 32'(seg_out),   32'h12);

    // Page wrap and year-page blanks
    wait_frame();
    press();
    wait_frame();
    check("wrap page 2", 32'(page), 32'd2);
    wait_mod(2);
    check("year d0 seg", 32'(seg_out), 32'h30);
    wait_mod(34);
    check("year d4 dig", 32'(dig_sel_n), 32'h2F);
    check("year d4 seg", 32'(seg_out),   32'h7F);
    wait_mod(42);
    check("year d5 dig", 32'(dig_sel_n), 32'h1F);
    check("year d5 seg", 32'(seg_out),   32'h7F);
    wait_frame();
    press();
    wait_frame();
    check("wrap page 0", 32'(page), 32'd0);
    wait_frame();
    press();
    wait_frame();
    check("wrap page 1", 32'(page), 32'd1);

    // Two presses in one frame coalesce
    wait_frame();
    btn = 1'b0; repeat (8) tick();
    btn = 1'b1; repeat (8) tick();
    btn = 1'b0; repeat (8) tick();
    btn = 1'b1; repeat (10) tick();
    wait_frame();
    check("coalesce page", 32'(page), 32'd2);
    wait_frame();
    check("coalesce page stable", 32'(page), 32'd2);

    // Reset discards a pending advance
    wait_frame();
    press();
    repeat (8) tick();
    glob_rst_n = 1'b0;
    repeat (3) tick();
    check("reset pend page",    32'(page),      32'd0);
    check("reset pend seg_out", 32'(seg_out),   32'h7F);
    check("reset pend dig",     32'(dig_sel_n), 32'h3E);
    glob_rst_n = 1'b1;
    repeat (3) tick();
    wait_frame();
    wait_frame();
    check("reset pend cleared", 32'(page), 32'd0);

    // Randomized phase, checked by the per-cycle model compare
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) din[$urandom_range(0, 13)] = 7'($urandom);
      if (hold == 0) begin
        btn  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 14);
      end
      hold--;
      if ($urandom_range(0, 999) == 0) begin
        glob_rst_n = 1'b0;
        tick();
        tick();
        glob_rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
